// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit_pkg
//  Description : Shared branch-prediction constants (entry layout, default
//                queue depth, misprediction counter width). The BTB reuses
//                the same package.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    localparam int c_bp_awidth    = 32;
    localparam int c_bp_depth     = 4;
    localparam int c_bp_cnt_width = 16;

    localparam logic [c_bp_cnt_width-1:0] c_bp_cnt_max = '1;

    // A queued prediction is {pc, pred_taken, pred_target}
    function automatic int bp_entry_width(input int awidth);
        return 2 * awidth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pred_fifo
//  Description : Synchronous FIFO holding in-flight branch predictions.
//                flush empties the queue and overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module pred_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_pw = $clog2(DEPTH);

    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_pw:0]   count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic w_push_ok;
    logic w_pop_ok;

    // Full is judged on registered state only, so a push while full is
    // dropped even when a pop happens in the same cycle
    assign full      = (count_q == (c_pw+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign w_push_ok = push & ~full & ~flush;
    assign w_pop_ok  = pop & ~empty;

    // Next pointer/occupancy; pointers wrap naturally since DEPTH is 2^n
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_ok) wr_ptr_d = wr_ptr_q + c_pw'(1);
            if (w_pop_ok)  rd_ptr_d = rd_ptr_q + c_pw'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_d = count_q + (c_pw+1)'(1);
                2'b01:   count_d = count_q - (c_pw+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Queues fetch-stage branch predictions and checks them
//                against execute-stage outcomes. Produces a registered
//                redirect/flush pulse, a BTB update request and a
//                saturating misprediction count.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int AWIDTH = c_bp_awidth,
    parameter int DEPTH  = c_bp_depth
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_f,
    input  logic [AWIDTH-1:0]         PC_f,
    input  logic                      pred_taken_f,
    input  logic [AWIDTH-1:0]         pred_target_f,
    input  logic                      resolve_x,
    input  logic [AWIDTH-1:0]         PC_x,
    input  logic                      taken_x,
    input  logic [AWIDTH-1:0]         alu_out,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      mispredict,
    output logic [AWIDTH-1:0]         redirect_pc,
    output logic                      btb_wr,
    output logic [AWIDTH-1:0]         btb_pc,
    output logic [AWIDTH-1:0]         btb_target,
    output logic [c_bp_cnt_width-1:0] mispred_cnt,
    output logic                      underflow
);

    localparam int c_ew = bp_entry_width(AWIDTH);

    logic [c_ew-1:0]   w_entry;
    logic [c_ew-1:0]   w_head;
    logic [AWIDTH-1:0] w_head_pc;
    logic              w_head_taken;
    logic [AWIDTH-1:0] w_head_target;
    logic              w_resolve_ok;
    logic              w_miss;

    logic                      mispredict_q,  mispredict_d;
    logic [AWIDTH-1:0]         redirect_pc_q, redirect_pc_d;
    logic                      btb_wr_q,      btb_wr_d;
    logic [AWIDTH-1:0]         btb_pc_q,      btb_pc_d;
    logic [AWIDTH-1:0]         btb_target_q,  btb_target_d;
    logic [c_bp_cnt_width-1:0] mispred_cnt_q, mispred_cnt_d;
    logic                      underflow_q,   underflow_d;

    assign w_entry       = {PC_f, pred_taken_f, pred_target_f};
    assign w_head_pc     = w_head[c_ew-1 -: AWIDTH];
    assign w_head_taken  = w_head[AWIDTH];
    assign w_head_target = w_head[AWIDTH-1:0];

    // A resolve against an empty queue is ignored apart from underflow
    assign w_resolve_ok = resolve_x & ~empty;
    assign w_miss = w_resolve_ok &
                    ((w_head_pc != PC_x) ||
                     (w_head_taken != taken_x) ||
                     (taken_x && (w_head_target != alu_out)));

    pred_fifo #(
        .WIDTH (c_ew),
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_f),
        .pop   (w_resolve_ok),
        .flush (w_miss),
        .wdata (w_entry),
        .rdata (w_head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Next-state of the redirect, BTB-update and statistics registers
    always_comb begin
        mispredict_d  = w_miss;
        redirect_pc_d = redirect_pc_q;
        btb_wr_d      = w_resolve_ok & taken_x;
        btb_pc_d      = btb_pc_q;
        btb_target_d  = btb_target_q;
        mispred_cnt_d = mispred_cnt_q;
        underflow_d   = underflow_q | (resolve_x & empty);
        if (w_miss) begin
            redirect_pc_d = taken_x ? alu_out : (PC_x + AWIDTH'(4));
            if (mispred_cnt_q != c_bp_cnt_max) begin
                mispred_cnt_d = mispred_cnt_q + c_bp_cnt_width'(1);
            end
        end
        if (w_resolve_ok && taken_x) begin
            btb_pc_d     = PC_x;
            btb_target_d = alu_out;
        end
    end

    // Output registers; reset suppresses any pending pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            btb_wr_q      <= 1'b0;
            btb_pc_q      <= '0;
            btb_target_q  <= '0;
            mispred_cnt_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            btb_wr_q      <= btb_wr_d;
            btb_pc_q      <= btb_pc_d;
            btb_target_q  <= btb_target_d;
            mispred_cnt_q <= mispred_cnt_d;
            underflow_q   <= underflow_d;
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign btb_wr      = btb_wr_q;
    assign btb_pc      = btb_pc_q;
    assign btb_target  = btb_target_q;
    assign mispred_cnt = mispred_cnt_q;
    assign underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Directed scoreboard bench for branch_resolve_unit. Stimulus
//                queues the expected redirect/BTB pulse for each resolve; a
//                monitor pops and compares whenever a pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int AW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_f;
    logic [AW-1:0] PC_f;
    logic          pred_taken_f;
    logic [AW-1:0] pred_target_f;
    logic          resolve_x;
    logic [AW-1:0] PC_x;
    logic          taken_x;
    logic [AW-1:0] alu_out;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic          btb_wr;
    logic [AW-1:0] btb_pc;
    logic [AW-1:0] btb_target;
    logic [15:0]   mispred_cnt;
    logic          underflow;

    typedef struct {
        int            due;
        logic          mis;
        logic [AW-1:0] redir;
        logic          btb;
        logic [AW-1:0] bpc;
        logic [AW-1:0] btgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    branch_resolve_unit #(.AWIDTH(AW), .DEPTH(DP)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_f        (push_f),
        .PC_f          (PC_f),
        .pred_taken_f  (pred_taken_f),
        .pred_target_f (pred_target_f),
        .resolve_x     (resolve_x),
        .PC_x          (PC_x),
        .taken_x       (taken_x),
        .alu_out       (alu_out),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .btb_wr        (btb_wr),
        .btb_pc        (btb_pc),
        .btb_target    (btb_target),
        .mispred_cnt   (mispred_cnt),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missing_pulse: expected pulse at cycle %0d not observed by cycle %0d", e.due, cyc);
        end
        if (mispredict === 1'b1 || btb_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: mispredict=%b btb_wr=%b at cycle %0d, expected no pulse",
                         mispredict, btb_wr, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.due);
                check("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
                if (e.mis) check("redirect_pc", redirect_pc, e.redir);
                check("btb_wr", {31'd0, btb_wr}, {31'd0, e.btb});
                if (e.btb) begin
                    check("btb_pc", btb_pc, e.bpc);
                    check("btb_target", btb_target, e.btgt);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue the pulse it should cause
    task automatic drive(input logic p, input logic [AW-1:0] pcf, input logic ptk, input logic [AW-1:0] ptg,
                         input logic r, input logic [AW-1:0] pcx, input logic tk, input logic [AW-1:0] alu,
                         input logic e_mis, input logic [AW-1:0] e_redir, input logic e_btb);
        exp_t e;
        push_f        = p;
        PC_f          = pcf;
        pred_taken_f  = ptk;
        pred_target_f = ptg;
        resolve_x     = r;
        PC_x          = pcx;
        taken_x       = tk;
        alu_out       = alu;
        if (e_mis || e_btb) begin
            e.due   = cyc + 1;
            e.mis   = e_mis;
            e.redir = e_redir;
            e.btb   = e_btb;
            e.bpc   = pcx;
            e.btgt  = alu;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        push_f    = 1'b0;
        resolve_x = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic pt, input logic [AW-1:0] tg);
        drive(1'b1, pc, pt, tg, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic [AW-1:0] pcx, input logic tk, input logic [AW-1:0] alu,
                           input logic e_mis, input logic [AW-1:0] e_redir, input logic e_btb);
        drive(1'b0, '0, 1'b0, '0, 1'b1, pcx, tk, alu, e_mis, e_redir, e_btb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; push_f = 1'b0; PC_f = '0; pred_taken_f = 1'b0; pred_target_f = '0;
        resolve_x = 1'b0; PC_x = '0; taken_x = 1'b0; alu_out = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);

        // Correct taken prediction: BTB update only
        push(32'h100, 1'b1, 32'h200);
        check("c1_count", {29'd0, count}, 32'd1);
        resolve(32'h100, 1'b1, 32'h200, 1'b0, '0, 1'b1);
        check("c1_count_after", {29'd0, count}, 32'd0);

        // Predicted not-taken, actually taken
        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 32'h180, 1'b1, 32'h180, 1'b1);
        check("c2_mispred_cnt", {16'd0, mispred_cnt}, 32'd1);

        // Predicted taken, actually not taken: fall-through redirect
        push(32'h104, 1'b1, 32'h300);
        resolve(32'h104, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0);
        check("c3_mispred_cnt", {16'd0, mispred_cnt}, 32'd2);

        // Fill, overflow drop, concurrent push/pop, ordering across wrap
        push(32'h10, 1'b1, 32'h1010);
        push(32'h20, 1'b1, 32'h1020);
        push(32'h30, 1'b1, 32'h1030);
        push(32'h40, 1'b1, 32'h1040);
        check("c4_full", {31'd0, full}, 32'd1);
        check("c4_count", {29'd0, count}, 32'd4);
        push(32'h50, 1'b1, 32'h1050);
        check("c4_drop_count", {29'd0, count}, 32'd4);
        drive(1'b1, 32'h60, 1'b1, 32'h1060, 1'b1, 32'h10, 1'b1, 32'h1010, 1'b0, '0, 1'b1);
        check("c4_pop_full_push", {29'd0, count}, 32'd3);
        drive(1'b1, 32'h70, 1'b1, 32'h1070, 1'b1, 32'h20, 1'b1, 32'h1020, 1'b0, '0, 1'b1);
        check("c4_push_pop_count", {29'd0, count}, 32'd3);
        push(32'h80, 1'b1, 32'h1080);
        check("c4_refull", {31'd0, full}, 32'd1);
        resolve(32'h30, 1'b1, 32'h1030, 1'b0, '0, 1'b1);
        resolve(32'h40, 1'b1, 32'h1040, 1'b0, '0, 1'b1);
        resolve(32'h70, 1'b1, 32'h1070, 1'b0, '0, 1'b1);
        check("c4_count_1", {29'd0, count}, 32'd1);
        resolve(32'h80, 1'b1, 32'h1080, 1'b0, '0, 1'b1);
        check("c4_empty", {31'd0, empty}, 32'd1);
        check("c4_mispred_cnt", {16'd0, mispred_cnt}, 32'd2);

        // Mispredict flushes the queue and drops a concurrent push
        push(32'h200, 1'b0, 32'h0);
        push(32'h204, 1'b0, 32'h0);
        push(32'h208, 1'b0, 32'h0);
        drive(1'b1, 32'h20C, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1);
        check("c5_count", {29'd0, count}, 32'd0);
        check("c5_empty", {31'd0, empty}, 32'd1);
        check("c5_mispred_cnt", {16'd0, mispred_cnt}, 32'd3);
        resolve(32'h20C, 1'b1, 32'h20C, 1'b0, '0, 1'b0);
        check("c5_underflow", {31'd0, underflow}, 32'd1);
        check("c5_uf_count", {29'd0, count}, 32'd0);
        check("c5_uf_mispred_cnt", {16'd0, mispred_cnt}, 32'd3);
        @(posedge clk); #1;
        check("c5_underflow_sticky", {31'd0, underflow}, 32'd1);

        // Saturation: preload the counter just below its ceiling
        dut.mispred_cnt_q = 16'hFFFE;
        push(32'h300, 1'b0, 32'h0);
        resolve(32'h300, 1'b1, 32'h500, 1'b1, 32'h500, 1'b1);
        check("c6_cnt_max", {16'd0, mispred_cnt}, 32'hFFFF);
        push(32'h300, 1'b1, 32'h600);
        resolve(32'h300, 1'b0, 32'h0, 1'b1, 32'h304, 1'b0);
        check("c6_cnt_hold", {16'd0, mispred_cnt}, 32'hFFFF);

        // Reset dominates a mispredicting resolve and concurrent push
        push(32'h500, 1'b1, 32'h900);
        push(32'h504, 1'b1, 32'h904);
        rst = 1'b1;
        drive(1'b1, 32'h508, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        check("c7_count", {29'd0, count}, 32'd0);
        check("c7_empty", {31'd0, empty}, 32'd1);
        check("c7_mispredict", {31'd0, mispredict}, 32'd0);
        check("c7_redirect_pc", redirect_pc, 32'd0);
        check("c7_btb_wr", {31'd0, btb_wr}, 32'd0);
        check("c7_btb_pc", btb_pc, 32'd0);
        check("c7_btb_target", btb_target, 32'd0);
        check("c7_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        check("c7_underflow", {31'd0, underflow}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check("pending_expectations", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
